dec_mpp_qres_collect: RTL and testbench

Collects the quantized MPP residuals for one block from the four substream demultiplexer outputs (ss0..ss3). Each substream delivers a serial stream of residual bytes. When all four substreams have delivered a complete block, the collector registers them as four 16-entry arrays and pulses `blk_vld` for one cycle. It sits directly upstream of the MPP decode stage, which consumes `mpp_qres_ssm0..3` and `blk_vld`.

---
 rtl/dec_mpp_pkg.sv | 15 +
 rtl/dec_mpp_qres_collect_if.sv | 37 +++
 rtl/dec_mpp_ss_buf.sv | 52 +++++
 rtl/dec_mpp_qres_collect.sv | 70 +++++++
 tb/tb_dec_mpp_qres_collect.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dec_mpp_pkg.sv
// Shared definitions for the MPP residual path.
// Used by the residual collector and by the MPP decode stage.
//   W  : residual sample width in bits
//   NS : samples delivered per substream per block
//   NO : entries per output residual array (entries NS..NO-1 are always 0)
package dec_mpp_pkg;

    localparam int W  = 8;
    localparam int NS = 12;
    localparam int NO = 16;

    typedef logic [W-1:0] qres_t;
    typedef qres_t        qres_arr_t [0:NO-1];

endpackage

// File: rtl/dec_mpp_qres_collect_if.sv
// Handshake and result bundle of the MPP residual collector.
//   flush          : abandon the partially collected block
//   ss_vld/ss_data : per-substream residual sample offer (upstream -> collector)
//   ss_rdy         : per-substream accept (collector -> upstream)
//   blk_vld        : one-cycle pulse, the four result arrays hold a new block
//   mpp_qres_ssm*  : collected residuals, one array per substream
//   blk_cnt        : blocks emitted since reset (wrapping)
// master = demux/decoder side, slave = collector.
interface dec_mpp_qres_collect_if
    import dec_mpp_pkg::*;
#(
    parameter int W  = dec_mpp_pkg::W,
    parameter int NO = dec_mpp_pkg::NO
);
    logic          flush;
    logic [3:0]    ss_vld;
    logic [W-1:0]  ss_data [0:3];
    logic [3:0]    ss_rdy;
    logic          blk_vld;
    logic [W-1:0]  mpp_qres_ssm0 [0:NO-1];
    logic [W-1:0]  mpp_qres_ssm1 [0:NO-1];
    logic [W-1:0]  mpp_qres_ssm2 [0:NO-1];
    logic [W-1:0]  mpp_qres_ssm3 [0:NO-1];
    logic [15:0]   blk_cnt;

    modport master (
        output flush, ss_vld, ss_data,
        input  ss_rdy, blk_vld, mpp_qres_ssm0, mpp_qres_ssm1,
               mpp_qres_ssm2, mpp_qres_ssm3, blk_cnt
    );

    modport slave (
        input  flush, ss_vld, ss_data,
        output ss_rdy, blk_vld, mpp_qres_ssm0, mpp_qres_ssm1,
               mpp_qres_ssm2, mpp_qres_ssm3, blk_cnt
    );
endinterface

// File: rtl/dec_mpp_ss_buf.sv
// Fill buffer for one substream: accepts up to NS samples in arrival order
// and then holds them until the block is transferred or flushed.
//   clk, rstn : clock, synchronous active-low reset
//   clear     : transfer or flush this cycle; empties the buffer at the edge
//   vld, data : incoming sample offer
//   rdy       : sample accepted this cycle
//   full      : NS samples held
//   fill_buf  : buffered samples, entry i = i-th accepted sample
module dec_mpp_ss_buf
    import dec_mpp_pkg::*;
#(
    parameter int W  = dec_mpp_pkg::W,
    parameter int NS = dec_mpp_pkg::NS
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         vld,
    input  logic [W-1:0] data,
    output logic         rdy,
    output logic         full,
    output logic [W-1:0] fill_buf [0:NS-1]
);
    localparam int CW = $clog2(NS + 1);

    logic [CW-1:0] cnt;

    assign full = (cnt == CW'(NS));
    // clear is only raised by a transfer (which needs full) or by flush, so
    // gating on it is equivalent to gating on flush alone.
    assign rdy  = !full && !clear && rstn;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (vld && rdy) begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: the sample storage is deliberately not reset; cnt alone marks
    // which entries are valid, and entries are only read once all are written.
    always_ff @(posedge clk) begin
        if (vld && rdy) begin
            fill_buf[cnt] <= data;
        end
    end
endmodule

// File: rtl/dec_mpp_qres_collect.sv
// Collects quantized MPP residuals from the four substream demultiplexers.
// Once every substream has delivered NS samples, the four blocks are copied
// into the output arrays together and blk_vld pulses for one cycle.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : slave side of dec_mpp_qres_collect_if (flush, ss_* handshake,
//               blk_vld, mpp_qres_ssm0..3, blk_cnt)
module dec_mpp_qres_collect
    import dec_mpp_pkg::*;
#(
    parameter int W  = dec_mpp_pkg::W,
    parameter int NS = dec_mpp_pkg::NS,
    parameter int NO = dec_mpp_pkg::NO
) (
    input  logic                   clk,
    input  logic                   rstn,
    dec_mpp_qres_collect_if.slave  bus
);
    logic [3:0]   full;
    logic [3:0]   rdy;
    logic [W-1:0] fill [0:3][0:NS-1];
    logic         all_full;
    logic         xfer;
    logic         clear;

    // Evaluated on registered counts, so the transfer edge always comes one
    // edge after the last substream's final accept (the per-block bubble).
    assign all_full = &full;
    assign xfer     = all_full && !bus.flush;
    assign clear    = xfer || bus.flush;

    for (genvar k = 0; k < 4; k++) begin : g_ss
        dec_mpp_ss_buf #(.W(W), .NS(NS)) u_ss_buf (
            .clk      (clk),
            .rstn     (rstn),
            .clear    (clear),
            .vld      (bus.ss_vld[k]),
            .data     (bus.ss_data[k]),
            .rdy      (rdy[k]),
            .full     (full[k]),
            .fill_buf (fill[k])
        );
    end

    assign bus.ss_rdy = rdy;

    // Entries NS..NO-1 are only ever written by reset, so they stay 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.blk_vld <= 1'b0;
            bus.blk_cnt <= '0;
            for (int i = 0; i < NO; i++) begin
                bus.mpp_qres_ssm0[i] <= '0;
                bus.mpp_qres_ssm1[i] <= '0;
                bus.mpp_qres_ssm2[i] <= '0;
                bus.mpp_qres_ssm3[i] <= '0;
            end
        end else begin
            bus.blk_vld <= xfer;
            if (xfer) begin
                bus.blk_cnt <= bus.blk_cnt + 16'd1;
                for (int i = 0; i < NS; i++) begin
                    bus.mpp_qres_ssm0[i] <= fill[0][i];
                    bus.mpp_qres_ssm1[i] <= fill[1][i];
                    bus.mpp_qres_ssm2[i] <= fill[2][i];
                    bus.mpp_qres_ssm3[i] <= fill[3][i];
                end
            end
        end
    end
endmodule

// File: tb/tb_dec_mpp_qres_collect.sv
module tb_dec_mpp_qres_collect;
    import dec_mpp_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    dec_mpp_qres_collect_if bus_if ();

    dec_mpp_qres_collect dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: per-substream queue of samples accepted into the
    // current block, the expected output arrays and the block counter.
    logic [7:0]  q       [4][$];
    logic [7:0]  src     [4][$];
    logic [7:0]  exp_arr [4][NO];
    logic [15:0] exp_cnt;
    bit          exp_vld;
    int          vld_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] dut_out(input int k, input int i);
        case (k)
            0:       return bus_if.mpp_qres_ssm0[i];
            1:       return bus_if.mpp_qres_ssm1[i];
            2:       return bus_if.mpp_qres_ssm2[i];
            default: return bus_if.mpp_qres_ssm3[i];
        endcase
    endfunction

    // One clock cycle: present samples from src (where 'want' allows),
    // check ss_rdy, advance the model, then check outputs after the edge.
    task automatic cycle(input bit fl, input logic [3:0] want);
        logic [3:0] vld;
        logic [3:0] mrdy;
        bit         full_all;
        for (int k = 0; k < 4; k++) begin
            vld[k] = want[k] && (src[k].size() > 0);
            bus_if.ss_vld[k]  = vld[k];
            bus_if.ss_data[k] = vld[k] ? src[k][0] : 8'($urandom);
        end
        bus_if.flush = fl;
        #1;
        for (int k = 0; k < 4; k++)
            mrdy[k] = rstn && !fl && (q[k].size() < NS);
        chk("ss_rdy", 32'(bus_if.ss_rdy), 32'(mrdy));

        full_all = 1'b1;
        for (int k = 0; k < 4; k++)
            if (q[k].size() != NS) full_all = 1'b0;
        exp_vld = 1'b0;
        if (!rstn) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                for (int i = 0; i < NO; i++) exp_arr[k][i] = 8'h00;
            end
            exp_cnt = 16'd0;
        end else if (fl) begin
            for (int k = 0; k < 4; k++) q[k].delete();
        end else if (full_all) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < NO; i++) begin
                    if (i < NS) exp_arr[k][i] = q[k][i];
                    else        exp_arr[k][i] = 8'h00;
                end
                q[k].delete();
            end
            exp_vld = 1'b1;
            exp_cnt = exp_cnt + 16'd1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (vld[k] && mrdy[k]) q[k].push_back(src[k].pop_front());
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("blk_vld", 32'(bus_if.blk_vld), 32'(exp_vld));
        chk("blk_cnt", 32'(bus_if.blk_cnt), 32'(exp_cnt));
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = 0;
            for (int i = NO - 1; i >= 0; i--)
                if (dut_out(k, i) !== exp_arr[k][i]) idx = i;
            chk($sformatf("ssm%0d[%0d]", k, idx), 32'(dut_out(k, idx)), 32'(exp_arr[k][idx]));
        end
        if (bus_if.blk_vld === 1'b1) vld_cyc.push_back(cyc);
    endtask

    initial begin
        int start;
        int base;
        logic [7:0] first0;
        logic [7:0] last1;

        bus_if.flush  = 1'b0;
        bus_if.ss_vld = 4'h0;
        for (int k = 0; k < 4; k++) bus_if.ss_data[k] = 8'h00;
        exp_cnt = 16'd0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NO; i++) exp_arr[k][i] = 8'h00;
        @(negedge clk);

        // Reset state and release.
        rstn = 1'b0;
        repeat (2) cycle(1'b0, 4'h0);
        chk("rst_blk_vld", 32'(bus_if.blk_vld), 32'd0);
        chk("rst_blk_cnt", 32'(bus_if.blk_cnt), 32'd0);
        rstn = 1'b1;
        bus_if.ss_vld = 4'h0;
        #1;
        chk("rdy_after_rst", 32'(bus_if.ss_rdy), 32'hF);

        // Continuous stream: substream k sends 0x10*k + i.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NS; i++) src[k].push_back(8'(16 * k + i));
        start = cyc;
        base  = vld_cyc.size();
        repeat (16) cycle(1'b0, 4'hF);
        chk("cont_pulses", 32'(vld_cyc.size() - base), 32'd1);
        if (vld_cyc.size() > base)
            chk("cont_latency", 32'(vld_cyc[base] - start), 32'd13);
        chk("cont_ssm2_5", 32'(bus_if.mpp_qres_ssm2[5]), 32'h25);
        chk("cont_ssm3_11", 32'(bus_if.mpp_qres_ssm3[11]), 32'h3B);
        chk("cont_ssm0_0", 32'(bus_if.mpp_qres_ssm0[0]), 32'h00);
        chk("cont_ssm1_11", 32'(bus_if.mpp_qres_ssm1[11]), 32'h1B);
        for (int i = NS; i < NO; i++)
            chk("cont_pad", 32'(bus_if.mpp_qres_ssm3[i]), 32'h00);
        chk("cont_blk_cnt", 32'(bus_if.blk_cnt), 32'd1);

        // Staggered arrival: ss0 done at cycle 12, ss3 at cycle 40.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NS; i++) src[k].push_back(8'($urandom));
        start = cyc;
        base  = vld_cyc.size();
        for (int c = 1; c <= 45; c++) begin
            logic [3:0] want;
            want[0] = (c <= 12);
            want[1] = ($urandom_range(1) == 1) || (src[1].size() >= 40 - c);
            want[2] = ($urandom_range(1) == 1) || (src[2].size() >= 40 - c);
            want[3] = (c == 40) || ((c < 40) && (src[3].size() > 1) &&
                      (($urandom_range(2) == 0) || (src[3].size() - 1 >= 40 - c)));
            cycle(1'b0, want);
            if (c >= 13 && c <= 40)
                chk("stag_rdy0_low", 32'(bus_if.ss_rdy[0]), 32'd0);
        end
        chk("stag_pulses", 32'(vld_cyc.size() - base), 32'd1);
        if (vld_cyc.size() > base)
            chk("stag_latency", 32'(vld_cyc[base] - start), 32'd41);

        // Flush with cnt = {5, 12, 0, 7}, then a fresh block.
        for (int i = 0; i < 5;  i++) src[0].push_back(8'($urandom));
        for (int i = 0; i < 12; i++) src[1].push_back(8'($urandom));
        for (int i = 0; i < 7;  i++) src[3].push_back(8'($urandom));
        base = vld_cyc.size();
        repeat (12) cycle(1'b0, 4'hF);
        cycle(1'b1, 4'hF);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NS; i++) src[k].push_back(8'($urandom));
        first0 = src[0][0];
        last1  = src[1][NS-1];
        repeat (16) cycle(1'b0, 4'hF);
        chk("flush_pulses", 32'(vld_cyc.size() - base), 32'd1);
        chk("flush_ssm0_0", 32'(bus_if.mpp_qres_ssm0[0]), 32'(first0));
        chk("flush_ssm1_11", 32'(bus_if.mpp_qres_ssm1[11]), 32'(last1));

        // Flush coincident with all_full.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NS; i++) src[k].push_back(8'($urandom));
        base = vld_cyc.size();
        repeat (12) cycle(1'b0, 4'hF);
        cycle(1'b1, 4'hF);
        cycle(1'b0, 4'h0);
        chk("flushfull_pulses", 32'(vld_cyc.size() - base), 32'd0);
        chk("flushfull_blk_cnt", 32'(bus_if.blk_cnt), 32'd3);
        chk("flushfull_rdy", 32'(bus_if.ss_rdy), 32'hF);

        // Reset mid-block.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NS; i++) src[k].push_back(8'($urandom));
        repeat (6) cycle(1'b0, 4'hF);
        rstn = 1'b0;
        repeat (2) cycle(1'b0, 4'hF);
        chk("midrst_blk_cnt", 32'(bus_if.blk_cnt), 32'd0);
        chk("midrst_ssm1_3", 32'(bus_if.mpp_qres_ssm1[3]), 32'd0);
        chk("midrst_ssm3_0", 32'(bus_if.mpp_qres_ssm3[0]), 32'd0);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) src[k].delete();

        // 100 back-to-back blocks.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 100 * NS; i++) src[k].push_back(8'($urandom));
        start = cyc;
        base  = vld_cyc.size();
        repeat (100 * 13 + 3) cycle(1'b0, 4'hF);
        chk("b2b_pulses", 32'(vld_cyc.size() - base), 32'd100);
        if (vld_cyc.size() > base)
            chk("b2b_first", 32'(vld_cyc[base] - start), 32'd13);
        for (int j = base + 1; j < vld_cyc.size(); j++)
            chk($sformatf("b2b_gap%0d", j - base), 32'(vld_cyc[j] - vld_cyc[j-1]), 32'd13);
        chk("b2b_blk_cnt", 32'(bus_if.blk_cnt), 32'd100);
        for (int k = 0; k < 4; k++)
            chk($sformatf("b2b_drained%0d", k), 32'(src[k].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
